// File: rtl/mem_stage.sv
// Memory stage of the pipelined ARMv8 core: EX/MEM register, doubleword data
// memory, CBZ/B resolution, MEM/WB register and the EX-operand forwarding unit.
// Stage suffixes: _p1 = EX/MEM contents, _p2 = MEM/WB contents.
module mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] alu_result,
  input  logic [63:0] alu_in2_out,
  input  logic        zero,
  input  logic [63:0] branch_target,
  input  logic [4:0]  ID_EX_rd,
  input  logic [4:0]  ID_EX_rn,
  input  logic [4:0]  ID_EX_rm,
  input  logic        ID_EX_mem_read,
  input  logic        ID_EX_mem_write,
  input  logic        ID_EX_branch,
  input  logic        ID_EX_uncond,
  input  logic        ID_EX_reg_write,
  input  logic        ID_EX_mem_to_reg,
  output logic [63:0] EX_MEM_alu_result,
  output logic [63:0] WB_write_back,
  output logic [4:0]  WB_rd,
  output logic        WB_reg_write,
  output logic        pc_src,
  output logic [63:0] pc_branch,
  output logic        flush,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB
);

  localparam logic [4:0] XZR = 5'd31;

  // EX/MEM fields
  logic [63:0] r_alu_p1, r_store_p1, r_target_p1;
  logic        r_zero_p1;
  logic [4:0]  r_rd_p1;
  logic        r_mem_read_p1, r_mem_write_p1, r_branch_p1, r_uncond_p1;
  logic        r_reg_write_p1, r_mem_to_reg_p1;

  // MEM/WB fields
  logic [63:0] r_rdata_p2, r_alu_p2;
  logic [4:0]  r_rd_p2;
  logic        r_reg_write_p2, r_mem_to_reg_p2;

  // Data memory (deliberately not reset)
  logic [63:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic [63:0]       w_rdata;
  logic              w_take;

  // Forwarding select for one EX source register; EX/MEM wins over MEM/WB, XZR never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic rw_p1, input logic [4:0] rd_p1,
                                         input logic rw_p2, input logic [4:0] rd_p2);
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_p1 && rd_p1 != XZR && rd_p1 == rs)
      sel = 2'b10;
    else if (rw_p2 && rd_p2 != XZR && rd_p2 == rs)
      sel = 2'b01;
    return sel;
  endfunction

  // Doubleword index: byte offset bits dropped, upper bits wrap.
  assign w_idx   = r_alu_p1[ADDR_W+2:3];
  assign w_rdata = r_mem[w_idx];
  assign w_take  = (r_branch_p1 & r_zero_p1) | r_uncond_p1;

  // ---- EX -> EX/MEM boundary ----
  // EX/MEM register; a taken branch turns the incoming instruction into a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_p1         <= '0;
      r_store_p1       <= '0;
      r_target_p1      <= '0;
      r_zero_p1        <= 1'b0;
      r_rd_p1          <= '0;
      r_mem_read_p1    <= 1'b0;
      r_mem_write_p1   <= 1'b0;
      r_branch_p1      <= 1'b0;
      r_uncond_p1      <= 1'b0;
      r_reg_write_p1   <= 1'b0;
      r_mem_to_reg_p1  <= 1'b0;
    end else begin
      r_alu_p1         <= alu_result;
      r_store_p1       <= alu_in2_out;
      r_target_p1      <= branch_target;
      r_zero_p1        <= zero;
      r_rd_p1          <= ID_EX_rd;
      r_mem_read_p1    <= ID_EX_mem_read   & ~w_take;
      r_mem_write_p1   <= ID_EX_mem_write  & ~w_take;
      r_branch_p1      <= ID_EX_branch     & ~w_take;
      r_uncond_p1      <= ID_EX_uncond     & ~w_take;
      r_reg_write_p1   <= ID_EX_reg_write  & ~w_take;
      r_mem_to_reg_p1  <= ID_EX_mem_to_reg & ~w_take;
    end
  end

  // Store commits at the edge ending the MEM cycle; a store caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (r_mem_write_p1 && !reset)
      r_mem[w_idx] <= r_store_p1;
  end

  // ---- EX/MEM -> MEM/WB boundary ----
  // MEM/WB register; read data is zeroed for non-loads so no stale word travels on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata_p2      <= '0;
      r_alu_p2        <= '0;
      r_rd_p2         <= '0;
      r_reg_write_p2  <= 1'b0;
      r_mem_to_reg_p2 <= 1'b0;
    end else begin
      r_rdata_p2      <= r_mem_read_p1 ? w_rdata : '0;
      r_alu_p2        <= r_alu_p1;
      r_rd_p2         <= r_rd_p1;
      r_reg_write_p2  <= r_reg_write_p1;
      r_mem_to_reg_p2 <= r_mem_to_reg_p1;
    end
  end

  assign EX_MEM_alu_result = r_alu_p1;
  assign pc_src            = w_take;
  assign flush             = w_take;
  assign pc_branch         = r_target_p1;
  assign WB_write_back     = r_mem_to_reg_p2 ? r_rdata_p2 : r_alu_p2;
  assign WB_rd             = r_rd_p2;
  assign WB_reg_write      = r_reg_write_p2;
  assign forwardA          = fwd_sel(ID_EX_rn, r_reg_write_p1, r_rd_p1, r_reg_write_p2, r_rd_p2);
  assign forwardB          = fwd_sel(ID_EX_rm, r_reg_write_p1, r_rd_p1, r_reg_write_p2, r_rd_p2);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU writeback latency, store/load with wrap,
// branch resolution and bubble, forwarding priority, asynchronous reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] alu_result, alu_in2_out, branch_target;
  logic        zero;
  logic [4:0]  ID_EX_rd, ID_EX_rn, ID_EX_rm;
  logic        ID_EX_mem_read, ID_EX_mem_write, ID_EX_branch, ID_EX_uncond;
  logic        ID_EX_reg_write, ID_EX_mem_to_reg;
  logic [63:0] EX_MEM_alu_result, WB_write_back, pc_branch;
  logic [4:0]  WB_rd;
  logic        WB_reg_write, pc_src, flush;
  logic [1:0]  forwardA, forwardB;

  int n_total = 0;
  int n_bad   = 0;

  mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .alu_result(alu_result), .alu_in2_out(alu_in2_out), .zero(zero),
    .branch_target(branch_target),
    .ID_EX_rd(ID_EX_rd), .ID_EX_rn(ID_EX_rn), .ID_EX_rm(ID_EX_rm),
    .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
    .ID_EX_branch(ID_EX_branch), .ID_EX_uncond(ID_EX_uncond),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_to_reg(ID_EX_mem_to_reg),
    .EX_MEM_alu_result(EX_MEM_alu_result), .WB_write_back(WB_write_back),
    .WB_rd(WB_rd), .WB_reg_write(WB_reg_write), .pc_src(pc_src),
    .pc_branch(pc_branch), .flush(flush),
    .forwardA(forwardA), .forwardB(forwardB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    alu_result = '0; alu_in2_out = '0; zero = 1'b0; branch_target = '0;
    ID_EX_rd = '0; ID_EX_rn = '0; ID_EX_rm = '0;
    ID_EX_mem_read = 1'b0; ID_EX_mem_write = 1'b0; ID_EX_branch = 1'b0;
    ID_EX_uncond = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_mem_to_reg = 1'b0;
  endtask

  task automatic stur(input logic [63:0] addr, input logic [63:0] data);
    nop();
    alu_result = addr; alu_in2_out = data; ID_EX_mem_write = 1'b1; ID_EX_rm = 5'd2;
  endtask

  task automatic ldur(input logic [63:0] addr, input logic [4:0] rd);
    nop();
    alu_result = addr; ID_EX_rd = rd;
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_mem_to_reg = 1'b1;
  endtask

  task automatic alu_op(input logic [63:0] res, input logic [4:0] rd, input logic rw);
    nop();
    alu_result = res; ID_EX_rd = rd; ID_EX_reg_write = rw;
  endtask

  initial begin
    nop();
    reset = 1'b1;
    tick(); tick();
    chk("rst_exm_alu", EX_MEM_alu_result, 64'h0);
    chk("rst_wb", WB_write_back, 64'h0);
    chk("rst_ctl", {59'h0, WB_reg_write, pc_src, flush, forwardA}, 64'h0);
    reset = 1'b0;

    // ADD rd=5 -> WB two edges later
    alu_op(64'h2A, 5'd5, 1'b1);
    tick();
    chk("add_exm", EX_MEM_alu_result, 64'h2A);
    chk("add_wb_early", {59'h0, WB_reg_write, WB_write_back[3:0]}, 64'h0);
    nop();
    tick();
    chk("add_wb", WB_write_back, 64'h2A);
    chk("add_rd", {58'h0, WB_reg_write, WB_rd}, {58'h0, 1'b1, 5'd5});

    // STUR 0x18, then LDUR 0x18 and wrapped LDUR 0x818
    stur(64'h18, 64'hDEADBEEF);
    tick();
    ldur(64'h18, 5'd7);
    tick();
    ldur(64'h818, 5'd8);
    tick();
    chk("ld_fwd_store", WB_write_back, 64'hDEADBEEF);
    chk("ld_rd", {59'h0, WB_rd}, 64'd7);
    nop();
    tick();
    chk("ld_wrap", WB_write_back, 64'hDEADBEEF);

    // CBZ taken; instruction behind it is squashed into a bubble
    nop(); ID_EX_branch = 1'b1; zero = 1'b1; branch_target = 64'h40;
    tick();
    chk("cbz_pc_src", {62'h0, pc_src, flush}, 64'h3);
    chk("cbz_target", pc_branch, 64'h40);
    stur(64'h18, 64'h1111);
    tick();
    chk("bubble_pc_src", {63'h0, pc_src}, 64'h0);
    ldur(64'h18, 5'd9);
    tick();
    nop();
    tick();
    chk("bubble_no_write", WB_write_back, 64'hDEADBEEF);

    // CBZ not taken, then B
    nop(); ID_EX_branch = 1'b1; zero = 1'b0; branch_target = 64'h80;
    tick();
    chk("cbz_nt", {62'h0, pc_src, flush}, 64'h0);
    nop(); ID_EX_uncond = 1'b1; zero = 1'b0; branch_target = 64'hC0;
    tick();
    chk("b_pc_src", {63'h0, pc_src}, 64'h1);
    chk("b_target", pc_branch, 64'hC0);
    nop();
    tick();
    chk("b_after", {63'h0, pc_src}, 64'h0);

    // Forwarding priority
    alu_op(64'h3, 5'd3, 1'b1);
    tick();
    alu_op(64'h3, 5'd3, 1'b0);
    ID_EX_reg_write = 1'b1;
    tick();
    ID_EX_rn = 5'd3; ID_EX_rm = 5'd3;
    #1;
    chk("fwdA_exm", {62'h0, forwardA}, 64'h2);
    chk("fwdB_exm", {62'h0, forwardB}, 64'h2);
    ID_EX_reg_write = 1'b0; ID_EX_rn = 5'd0; ID_EX_rm = 5'd0;
    tick();
    ID_EX_rn = 5'd3; ID_EX_rm = 5'd3;
    #1;
    chk("fwdA_wb", {62'h0, forwardA}, 64'h1);
    chk("fwdB_wb", {62'h0, forwardB}, 64'h1);
    ID_EX_rm = 5'd4;
    #1;
    chk("fwdB_none", {62'h0, forwardB}, 64'h0);
    alu_op(64'h0, 5'd31, 1'b1);
    tick();
    tick();
    ID_EX_rn = 5'd31; ID_EX_rm = 5'd31;
    #1;
    chk("fwdA_xzr", {62'h0, forwardA}, 64'h0);
    chk("fwdB_xzr", {62'h0, forwardB}, 64'h0);

    // Seed 0x8 with a known value
    stur(64'h8, 64'h77);
    tick();
    nop();
    tick();

    // Reset mid-cycle while a B sits in EX/MEM
    nop(); ID_EX_uncond = 1'b1; branch_target = 64'h100;
    tick();
    chk("pre_rst_pc_src", {63'h0, pc_src}, 64'h1);
    nop();
    #2 reset = 1'b1;
    #1;
    chk("rst_pc_src", {62'h0, pc_src, flush}, 64'h0);
    chk("rst_pc_branch", pc_branch, 64'h0);
    #4 reset = 1'b0;
    tick();

    // Reset mid-cycle while STUR 0x8 <- 0x1 sits in EX/MEM
    stur(64'h8, 64'h1);
    tick();
    chk("stur_exm", EX_MEM_alu_result, 64'h8);
    nop();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_exm", EX_MEM_alu_result, 64'h0);
    chk("rst_mid_wb", {57'h0, WB_reg_write, WB_rd, forwardA[0]}, 64'h0);
    tick();
    reset = 1'b0;
    ldur(64'h8, 5'd10);
    tick();
    nop();
    tick();
    chk("rst_drop_store", WB_write_back, 64'h77);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus stalls.
  initial begin
    #20000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the pipelined ARMv8 core. It sits directly downstream of the execution stage and contains:
- the EX/MEM pipeline register;
- the doubleword data memory for LDUR/STUR;
- branch resolution for CBZ/B;
- the MEM/WB pipeline register;
- the forwarding unit that produces the execution stage's forwardA/forwardB codes (00 = register file, 10 = EX/MEM, 01 = WB).

Parameters:
DEPTH, 256, number of 64-bit doublewords in data memory (power of two).
ADDR_W, 8, log2(DEPTH); doubleword index width.

Ports:
clk  input  1  core clock, rising-edge active
reset  input  1  asynchronous, active-high; one clock, no other clock domains
alu_result  input  64  ALU result from execution (address or arithmetic result)
alu_in2_out  input  64  forwarded second operand from execution (store data)
zero  input  1  ALU zero flag from execution
branch_target  input  64  pc_out + (sign_extend_in << 2), computed in EX
ID_EX_rd  input  5  destination register of instruction in EX
ID_EX_rn  input  5  first source register of instruction in EX
ID_EX_rm  input  5  second source register of instruction in EX (Rt for STUR/CBZ)
ID_EX_mem_read, ID_EX_mem_write, ID_EX_branch, ID_EX_uncond, ID_EX_reg_write, ID_EX_mem_to_reg  input  1 each  control bits of instruction in EX
EX_MEM_alu_result  output  64  registered ALU result (forwarding source 10)
WB_write_back  output  64  MEM/WB value selected by mem_to_reg (forwarding source 01)
WB_rd  output  5  MEM/WB destination register
WB_reg_write  output  1  MEM/WB register-file write enable
pc_src  output  1  take branch; PC loads pc_branch
pc_branch  output  64  registered branch target
flush  output  1  squash IF/ID and ID/EX contents
forwardA, forwardB  output  2 each  forwarding select codes for execution

Behaviour:
- Reset (asynchronous): every EX/MEM and MEM/WB field goes to 0. All outputs are therefore 0, including pc_src, flush and forwardA/B.
- Data memory contents are not cleared by reset.

EX/MEM register:
- Captures all ID_EX_* controls, alu_result, alu_in2_out, zero, branch_target and ID_EX_rd on every rising edge.
- Exception: when pc_src = 1 in the current cycle, it captures a bubble: all control bits 0, data fields don't-care.

Branch:
- pc_src = EX_MEM_branch & EX_MEM_zero | EX_MEM_uncond. This is combinational from EX/MEM.
- pc_branch = EX_MEM branch_target.
- flush = pc_src.
- Branches resolve one cycle after EX. The three younger instructions (IF, ID, EX) are squashed.

Data memory:
- Index = EX_MEM_alu_result[ADDR_W+2:3]. Bits [2:0] are ignored (no alignment fault). Upper bits are ignored, so addresses wrap modulo DEPTH*8.
- Write: on the rising edge when EX_MEM_mem_write = 1, using the EX/MEM store data.
- Read: combinational on the index; result is captured into MEM/WB.
- A store followed immediately by a load to the same address returns the stored value. The write completes at the edge that ends the store's MEM cycle.

MEM/WB register:
- Captures read data, EX_MEM_alu_result, rd, reg_write and mem_to_reg every edge.
- WB_write_back = mem_to_reg ? read data : alu result.

Forwarding (combinational, EX/MEM has priority over MEM/WB):
- forwardA = 10 if EX_MEM_reg_write & EX_MEM_rd != 31 & EX_MEM_rd == ID_EX_rn.
- Otherwise forwardA = 01 if WB_reg_write & WB_rd != 31 & WB_rd == ID_EX_rn.
- Otherwise forwardA = 00.
- forwardB: same rules with ID_EX_rm.
- Register 31 (XZR) is never forwarded.
- A load in EX/MEM forwards its address, not its data. The load-use stall belongs to the hazard detection unit in ID.

Latency:
- ALU result reaches WB_write_back 2 edges after leaving EX.
- Load data reaches WB_write_back 2 edges after leaving EX.

Reset mid-operation:
- In-flight instructions are dropped.
- A write pending in EX/MEM does not occur.
- pc_src deasserts immediately on reset.

Test Plan:
1. Reset then drive ADD with rd=5, alu_result=0x2A, reg_write=1 -> after 2 edges WB_write_back=0x2A, WB_rd=5, WB_reg_write=1. Before that all outputs are 0.
2. STUR at address 0x18 with data 0xDEADBEEF, next cycle LDUR at 0x18 with mem_to_reg=1 -> WB_write_back=0xDEADBEEF. LDUR at 0x818 (DEPTH=256) also returns 0xDEADBEEF (wrap).
3. CBZ with zero=1, branch_target=0x40 -> one edge later pc_src=1, flush=1, pc_branch=0x40. Next EX/MEM holds a bubble (no write even if ID_EX_mem_write=1). With zero=0 -> pc_src stays 0. B with uncond=1 -> pc_src=1 regardless of zero.
4. Forwarding: EX/MEM rd=3 reg_write=1, WB rd=3 reg_write=1, ID_EX_rn=3 -> forwardA=10. Clear EX/MEM reg_write -> forwardA=01. Set rd=31 on both -> forwardA=00. ID_EX_rm=3 gives the same results on forwardB.
5. Assert reset asynchronously, mid-cycle, while a STUR to 0x8 with data 0x1 sits in EX/MEM -> outputs go to 0 immediately. A later LDUR at 0x8 returns the prior contents, not 0x1.
